// File: rtl/bus_arbiter.sv
// bus_arbiter: registers the round-robin encoder's choice as a bus grant, runs
// the grant/acknowledge handshake, tracks bus ownership and revokes grants that
// are never acknowledged.
module bus_arbiter #(
  parameter int unsigned GRANT_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [4:0] requests,
  input  logic [4:0] ack,
  input  logic       bus_idle,
  output logic [4:0] rr_requests,
  output logic [4:0] rr_previous_grant,
  input  logic [4:0] rr_grant,
  output logic [4:0] grant,
  output logic [4:0] owner,
  output logic       busy,
  output logic       timeout
);

  localparam int unsigned NUM_MASTERS = 5;
  localparam int unsigned CNT_W       = $clog2(GRANT_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(GRANT_TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANTED = 2'd1,
    OWNED   = 2'd2
  } state_t;

  state_t                 state, state_next;
  logic [NUM_MASTERS-1:0] grant_next, owner_next;
  logic [NUM_MASTERS-1:0] prev_grant, prev_grant_next;
  logic [CNT_W-1:0]       counter, counter_next;
  logic                   timeout_next, busy_next;
  logic                   granted_ack, granted_req, owner_ack;

  // Encoder inputs: live request vector and the last issued grant
  assign rr_requests       = requests;
  assign rr_previous_grant = prev_grant;

  // Per-master qualifiers for the currently granted / owning master
  assign granted_ack = |(ack & grant);
  assign granted_req = |(requests & grant);
  assign owner_ack   = |(ack & owner);

  // State and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      grant      <= '0;
      owner      <= '0;
      prev_grant <= '0;
      counter    <= '0;
      timeout    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_next;
      grant      <= grant_next;
      owner      <= owner_next;
      prev_grant <= prev_grant_next;
      counter    <= counter_next;
      timeout    <= timeout_next;
      busy       <= busy_next;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_next      = state;
    grant_next      = grant;
    owner_next      = owner;
    prev_grant_next = prev_grant;
    counter_next    = counter;
    timeout_next    = 1'b0;

    case (state)
      IDLE: begin
        grant_next = '0;
        owner_next = '0;
        // Only start a new grant on a quiet bus with nobody still driving it
        if (bus_idle && (ack == '0) && (rr_grant != '0)) begin
          grant_next      = rr_grant;
          prev_grant_next = rr_grant;
          counter_next    = '0;
          state_next      = GRANTED;
        end
      end

      GRANTED: begin
        if (granted_ack) begin
          grant_next = '0;
          owner_next = grant;
          state_next = OWNED;
        end else if (!granted_req) begin
          grant_next = '0;
          state_next = IDLE;
        end else if (counter == CNT_LAST) begin
          grant_next   = '0;
          timeout_next = 1'b1;
          state_next   = IDLE;
        end else begin
          counter_next = counter + CNT_W'(1);
        end
      end

      OWNED: begin
        grant_next = '0;
        // Owner dropping its acknowledge hands the bus back
        if (!owner_ack) begin
          owner_next = '0;
          state_next = IDLE;
        end
      end

      default: begin
        grant_next = '0;
        owner_next = '0;
        state_next = IDLE;
      end
    endcase

    busy_next = (state_next != IDLE);
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed vectors; expected outputs are queued per cycle and a
// separate monitor pops and compares them against the DUT.
module tb_bus_arbiter;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [4:0] requests = '0;
  logic [4:0] ack = '0;
  logic       bus_idle = 1'b0;
  logic [4:0] rr_requests, rr_previous_grant, rr_grant;
  logic [4:0] grant, owner;
  logic       busy, timeout;

  int cyc = 0;
  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    int         tag;
    logic [4:0] g;
    logic [4:0] o;
    logic [4:0] p;
    logic       b;
    logic       t;
    string      nm;
  } exp_t;

  exp_t exp_q[$];
  logic [4:0] rot_seq [6];

  bus_arbiter #(.GRANT_TIMEOUT(4)) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .requests          (requests),
    .ack               (ack),
    .bus_idle          (bus_idle),
    .rr_requests       (rr_requests),
    .rr_previous_grant (rr_previous_grant),
    .rr_grant          (rr_grant),
    .grant             (grant),
    .owner             (owner),
    .busy              (busy),
    .timeout           (timeout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // External round-robin encoder: search starts just after the previous grant
  function automatic logic [4:0] rr_enc(input logic [4:0] req, input logic [4:0] prev);
    int start;
    int idx;
    logic [4:0] res;
    start = 0;
    res = '0;
    for (int i = 0; i < 5; i++) if (prev[i]) start = (i + 1) % 5;
    for (int k = 4; k >= 0; k--) begin
      idx = (start + k) % 5;
      if (req[idx]) begin
        res = '0;
        res[idx] = 1'b1;
      end
    end
    return res;
  endfunction

  always_comb rr_grant = rr_enc(rr_requests, rr_previous_grant);

  function automatic void push(input int tag, input logic [4:0] g, input logic [4:0] o,
                               input logic [4:0] p, input logic b, input logic t,
                               input string nm);
    exp_t e;
    e.tag = tag; e.g = g; e.o = o; e.p = p; e.b = b; e.t = t; e.nm = nm;
    exp_q.push_back(e);
  endfunction

  task automatic check(input exp_t e);
    n_vec++;
    if (e.tag != cyc || grant !== e.g || owner !== e.o || rr_previous_grant !== e.p ||
        busy !== e.b || timeout !== e.t || rr_requests !== requests) begin
      n_err++;
      $display("FAIL %s cyc=%0d(tag %0d): got grant=%b owner=%b prev=%b busy=%b timeout=%b rr_req=%b, want grant=%b owner=%b prev=%b busy=%b timeout=%b rr_req=%b",
               e.nm, cyc, e.tag, grant, owner, rr_previous_grant, busy, timeout, rr_requests,
               e.g, e.o, e.p, e.b, e.t, requests);
    end
  endtask

  // Monitor: compares queued expectations at mid-cycle and right after reset assertion
  initial begin
    exp_t e;
    forever begin
      @(negedge clk or negedge reset_n);
      #1;
      while (exp_q.size() > 0 && exp_q[0].tag <= cyc) begin
        e = exp_q.pop_front();
        check(e);
      end
    end
  end

  // Drive one cycle of inputs; expected outputs appear after the next edge
  task automatic step(input logic [4:0] r, input logic [4:0] a, input logic idle,
                      input logic [4:0] eg, input logic [4:0] eo, input logic [4:0] ep,
                      input logic eb, input logic et, input string nm);
    @(posedge clk);
    #1;
    requests = r;
    ack      = a;
    bus_idle = idle;
    push(cyc + 1, eg, eo, ep, eb, et, nm);
  endtask

  // Assert reset mid-cycle (outputs must clear at once), release a cycle later
  task automatic async_reset(input string nm);
    @(posedge clk);
    @(negedge clk);
    #2;
    requests = '0;
    ack      = '0;
    push(cyc, '0, '0, '0, 1'b0, 1'b0, {nm, "_assert"});
    reset_n  = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    push(cyc, '0, '0, '0, 1'b0, 1'b0, {nm, "_release"});
  endtask

  initial begin
    logic [4:0] x;
    rot_seq[0] = 5'b00001; rot_seq[1] = 5'b00010; rot_seq[2] = 5'b00100;
    rot_seq[3] = 5'b01000; rot_seq[4] = 5'b10000; rot_seq[5] = 5'b00001;

    // Reset state
    @(posedge clk); #1;
    push(cyc, '0, '0, '0, 1'b0, 1'b0, "reset_state");
    @(posedge clk); #1;
    reset_n = 1'b1;

    // Basic issue, acknowledge, release, rotation
    step(5'b00101, 5'b00000, 1'b1, 5'b00001, 5'b00000, 5'b00001, 1'b1, 1'b0, "issue_m0");
    step(5'b00101, 5'b00001, 1'b1, 5'b00000, 5'b00001, 5'b00001, 1'b1, 1'b0, "ack_m0");
    step(5'b00101, 5'b00000, 1'b1, 5'b00000, 5'b00000, 5'b00001, 1'b0, 1'b0, "release_m0");
    step(5'b00101, 5'b00000, 1'b1, 5'b00100, 5'b00000, 5'b00100, 1'b1, 1'b0, "rotate_m2");
    step(5'b00101, 5'b00100, 1'b1, 5'b00000, 5'b00100, 5'b00100, 1'b1, 1'b0, "ack_m2");
    step(5'b00000, 5'b00000, 1'b1, 5'b00000, 5'b00000, 5'b00100, 1'b0, 1'b0, "release_m2");

    // Full rotation with all masters requesting
    async_reset("rst_pre_rr");
    for (int k = 0; k < 6; k++) begin
      x = rot_seq[k];
      step(5'b11111, 5'b00000, 1'b1, x, 5'b00000, x, 1'b1, 1'b0, "rr_issue");
      step(5'b11111, 5'b00000, 1'b1, x, 5'b00000, x, 1'b1, 1'b0, "rr_wait");
      step(5'b11111, x,        1'b1, 5'b00000, x, x, 1'b1, 1'b0, "rr_ack");
      step(5'b11111, x,        1'b1, 5'b00000, x, x, 1'b1, 1'b0, "rr_own1");
      step(5'b11111, x,        1'b1, 5'b00000, x, x, 1'b1, 1'b0, "rr_own2");
      step(5'b11111, 5'b00000, 1'b1, 5'b00000, 5'b00000, x, 1'b0, 1'b0, "rr_release");
    end

    // Timeout: grant high exactly 4 cycles, then a one-cycle pulse
    step(5'b01000, 5'b00000, 1'b1, 5'b01000, 5'b00000, 5'b01000, 1'b1, 1'b0, "to_issue");
    step(5'b01000, 5'b00000, 1'b1, 5'b01000, 5'b00000, 5'b01000, 1'b1, 1'b0, "to_hold1");
    step(5'b01000, 5'b00000, 1'b1, 5'b01000, 5'b00000, 5'b01000, 1'b1, 1'b0, "to_hold2");
    step(5'b01000, 5'b00000, 1'b1, 5'b01000, 5'b00000, 5'b01000, 1'b1, 1'b0, "to_hold3");
    step(5'b01000, 5'b00000, 1'b1, 5'b00000, 5'b00000, 5'b01000, 1'b0, 1'b1, "to_pulse");
    step(5'b01000, 5'b00000, 1'b1, 5'b01000, 5'b00000, 5'b01000, 1'b1, 1'b0, "to_regrant_m3");
    step(5'b01000, 5'b00000, 1'b1, 5'b01000, 5'b00000, 5'b01000, 1'b1, 1'b0, "to2_hold1");
    step(5'b01000, 5'b00000, 1'b1, 5'b01000, 5'b00000, 5'b01000, 1'b1, 1'b0, "to2_hold2");
    step(5'b01000, 5'b00000, 1'b1, 5'b01000, 5'b00000, 5'b01000, 1'b1, 1'b0, "to2_hold3");
    step(5'b01000, 5'b00000, 1'b1, 5'b00000, 5'b00000, 5'b01000, 1'b0, 1'b1, "to2_pulse");
    step(5'b01001, 5'b00000, 1'b1, 5'b00001, 5'b00000, 5'b00001, 1'b1, 1'b0, "to_next_m0");
    step(5'b00000, 5'b00000, 1'b1, 5'b00000, 5'b00000, 5'b00001, 1'b0, 1'b0, "withdraw_m0");

    // Simultaneous ack and withdrawal on the last timeout cycle; stray ack ignored
    step(5'b00100, 5'b00000, 1'b1, 5'b00100, 5'b00000, 5'b00100, 1'b1, 1'b0, "sim_issue_m2");
    step(5'b00100, 5'b00010, 1'b1, 5'b00100, 5'b00000, 5'b00100, 1'b1, 1'b0, "stray_ack1_a");
    step(5'b00100, 5'b00010, 1'b1, 5'b00100, 5'b00000, 5'b00100, 1'b1, 1'b0, "stray_ack1_b");
    step(5'b00100, 5'b00000, 1'b1, 5'b00100, 5'b00000, 5'b00100, 1'b1, 1'b0, "sim_hold");
    step(5'b00000, 5'b00100, 1'b1, 5'b00000, 5'b00100, 5'b00100, 1'b1, 1'b0, "sim_ack_wins");
    step(5'b00000, 5'b00100, 1'b1, 5'b00000, 5'b00100, 5'b00100, 1'b1, 1'b0, "sim_owned");
    step(5'b00000, 5'b00000, 1'b1, 5'b00000, 5'b00000, 5'b00100, 1'b0, 1'b0, "sim_release");

    // Issue blocked by busy bus or stray acknowledge
    step(5'b00010, 5'b00000, 1'b0, 5'b00000, 5'b00000, 5'b00100, 1'b0, 1'b0, "blk_bus_busy");
    step(5'b00010, 5'b00001, 1'b1, 5'b00000, 5'b00000, 5'b00100, 1'b0, 1'b0, "blk_ack");
    step(5'b00010, 5'b00001, 1'b0, 5'b00000, 5'b00000, 5'b00100, 1'b0, 1'b0, "blk_both");
    step(5'b00010, 5'b00000, 1'b1, 5'b00010, 5'b00000, 5'b00010, 1'b1, 1'b0, "blk_cleared");
    step(5'b00000, 5'b00000, 1'b1, 5'b00000, 5'b00000, 5'b00010, 1'b0, 1'b0, "blk_withdraw");

    // Asynchronous reset during GRANTED and during OWNED
    step(5'b01000, 5'b00000, 1'b1, 5'b01000, 5'b00000, 5'b01000, 1'b1, 1'b0, "pre_rst_grant");
    async_reset("rst_granted");
    step(5'b10001, 5'b00000, 1'b1, 5'b00001, 5'b00000, 5'b00001, 1'b1, 1'b0, "post_rst_m0");
    step(5'b10001, 5'b00001, 1'b1, 5'b00000, 5'b00001, 5'b00001, 1'b1, 1'b0, "pre_rst_owned");
    async_reset("rst_owned");
    step(5'b00010, 5'b00000, 1'b1, 5'b00010, 5'b00000, 5'b00010, 1'b1, 1'b0, "post_rst_m1");
    step(5'b00000, 5'b00000, 1'b1, 5'b00000, 5'b00000, 5'b00010, 1'b0, 1'b0, "post_rst_wd");

    repeat (3) @(posedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_err = n_err + exp_q.size();
      $display("FAIL unchecked_expectations: %0d left in queue, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
